// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready skid buffer; transfer counter enabled by PIPE_SKID_BUFFER_XFER_CNT_EN
module pipe_skid_buffer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [1:0]           o_fill,
    output logic [CNT_WIDTH-1:0] o_xfer_cnt
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic in_fire, out_fire;
    assign o_valid  = state_q != EMPTY;
    assign o_ready  = state_q != FULL;
    assign o_fill   = state_q == FULL ? 2'd2 : state_q == BUSY ? 2'd1 : 2'd0;
    assign o_data   = main_q;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    // next state from the two handshakes; the skid entry only fills when the consumer stalls
    always_comb begin
        state_d = state_q;
        if (state_q == EMPTY)
            state_d = in_fire ? BUSY : EMPTY;
        else if (state_q == BUSY)
            state_d = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : BUSY;
        else
            state_d = out_fire ? BUSY : FULL;
    end
    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= EMPTY;
        else       state_q <= state_d;
    end
    // main_q takes a new beat when it is free or being drained, otherwise refills from skid_q
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (in_fire & (~o_valid | out_fire)) main_q <= i_data;
            else if (~o_ready & out_fire)         main_q <= skid_q;
            if (in_fire & o_valid & ~i_ready)     skid_q <= i_data;
        end
    end
`ifdef PIPE_SKID_BUFFER_XFER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    assign o_xfer_cnt = cnt_q;
    // free-running count of delivered beats, wraps silently
    always_ff @(posedge i_clk) begin
        if (i_rst)         cnt_q <= '0;
        else if (out_fire) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
`else
    assign o_xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: scoreboard bench for pipe_skid_buffer against a queue-based FIFO model
module tb_pipe_skid_buffer;
    localparam int W  = 16;
    localparam int CW = 4;
`ifdef PIPE_SKID_BUFFER_XFER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic          i_clk, i_rst, i_valid, o_ready, o_valid, i_ready;
    logic [W-1:0]  i_data, o_data;
    logic [1:0]    o_fill;
    logic [CW-1:0] o_xfer_cnt;
    logic [W-1:0]  exp_q[$];
    int n_cmp = 0, n_bad = 0, n_acc = 0;
    int m_fill = 0, m_del = 0;
    bit mon_en = 0, stall = 0;
    logic [W-1:0] stall_data;

    pipe_skid_buffer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_fill(o_fill), .o_xfer_cnt(o_xfer_cnt)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? 32'(m_del % (1 << CW)) : 32'd0;
    endfunction

    // monitor: mid-cycle, compare against the occupancy model and pop delivered beats
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            m_fill = 0;
            m_del  = 0;
            stall  = 0;
        end else if (mon_en) begin
            chk("o_valid", 32'(o_valid), 32'(m_fill != 0));
            chk("o_ready", 32'(o_ready), 32'(m_fill != 2));
            chk("o_fill", 32'(o_fill), 32'(m_fill));
            chk("o_xfer_cnt", 32'(o_xfer_cnt), exp_cnt());
            if (stall) chk("o_data stable", 32'(o_data), 32'(stall_data));
            stall      = o_valid && !i_ready;
            stall_data = o_data;
            if (m_fill != 0 && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL o_data: delivery with no expected beat at %0t", $time);
                end else begin
                    chk("o_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
                m_del++;
            end
            m_fill = m_fill + int'(i_valid && m_fill != 2) - int'(m_fill != 0 && i_ready);
        end
    end

    // one clock of stimulus; accepted beats enter the scoreboard
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(negedge i_clk);
        if (v && o_ready && !i_rst) begin
            exp_q.push_back(d);
            n_acc++;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1;
        cycle(0, '0, 0);
        i_rst = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        i_rst = 1; i_valid = 0; i_ready = 0; i_data = '0;
        @(posedge i_clk); #1;
        cycle(1, 16'hDEAD, 1);
        i_rst = 0;
        chk("rst o_valid", 32'(o_valid), 0);
        chk("rst o_ready", 32'(o_ready), 1);
        chk("rst o_fill", 32'(o_fill), 0);
        chk("rst o_data", 32'(o_data), 0);
        chk("rst o_xfer_cnt", 32'(o_xfer_cnt), 0);
        mon_en = 1;
        repeat (2) cycle(0, '0, 1);
        // streaming
        for (int i = 1; i <= 16; i++) cycle(1, W'(i), 1);
        cycle(0, '0, 1);
        chk("stream drained", 32'(exp_q.size()), 0);
        // stall absorb
        cycle(1, 16'hA, 0);
        cycle(1, 16'hB, 0);
        chk("stall o_ready", 32'(o_ready), 0);
        chk("stall o_fill", 32'(o_fill), 2);
        cycle(1, 16'hC, 0);
        chk("stall hold fill", 32'(o_fill), 2);
        chk("stall hold data", 32'(o_data), 32'hA);
        repeat (2) cycle(1, 16'hC, 1);
        repeat (2) cycle(0, '0, 1);
        chk("stall drained", 32'(exp_q.size()), 0);
        // reset mid-operation from FULL
        cycle(1, 16'h5, 0);
        cycle(1, 16'h6, 0);
        chk("pre-rst o_fill", 32'(o_fill), 2);
        i_rst = 1;
        cycle(1, 16'h7, 1);
        i_rst = 0;
        chk("mid-rst o_valid", 32'(o_valid), 0);
        chk("mid-rst o_ready", 32'(o_ready), 1);
        chk("mid-rst o_fill", 32'(o_fill), 0);
        chk("mid-rst o_data", 32'(o_data), 0);
        chk("mid-rst o_xfer_cnt", 32'(o_xfer_cnt), 0);
        repeat (3) cycle(0, '0, 1);
        // counter wrap
        do_reset();
        for (int i = 1; i <= 17; i++) cycle(1, W'(i + 16'h100), 1);
        cycle(0, '0, 1);
        chk("wrap o_xfer_cnt", 32'(o_xfer_cnt), CNT_EN ? 32'd1 : 32'd0);
        // random back-pressure
        do_reset();
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            cyc++;
        end
        chk("random accepted", 32'(n_acc >= 10000), 1);
        repeat (4) cycle(0, '0, 1);
        chk("random drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
